// File: rtl/conv_out_serializer.sv
// conv_out_serializer
// Takes one packed multi-channel accumulator beat per output pixel and emits the
// channels one per beat (channel 0 first). Each channel is arithmetically
// right-shifted and then saturated to signed WidthOut. The block also tracks the
// raster position and flags end-of-line and end-of-frame on the last channel.
// Optional build macro: CONV_OUT_RELU_EN clamps negative values to zero before
// saturation.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no pixel held; ready_o=1 to accept the next beat
//   SEND  | emitting the channels of cap_r; a new beat may be accepted on the
//         | last channel so that back-to-back pixels run without a bubble

module conv_out_serializer #(
   parameter int OutLineWidthPx = 158,
   parameter int OutLineCountPx = 118,
   parameter int OutChannels    = 2,
   parameter int WidthIn        = 32,
   parameter int WidthOut       = 8,
   parameter int ShiftAmt       = 0,
   localparam int ChW           = (OutChannels > 1) ? $clog2(OutChannels) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           valid_i,
   output logic                           ready_o,
   input  logic [OutChannels*WidthIn-1:0] data_i,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic [WidthOut-1:0]            data_o,
   output logic [ChW-1:0]                 ch_o,
   output logic                           eol_o,
   output logic                           eof_o
);

   localparam int XW = (OutLineWidthPx > 1) ? $clog2(OutLineWidthPx) : 1;
   localparam int YW = (OutLineCountPx > 1) ? $clog2(OutLineCountPx) : 1;
   localparam logic [ChW-1:0] CH_LAST = ChW'(OutChannels - 1);
   localparam logic [XW-1:0]  X_LAST  = XW'(OutLineWidthPx - 1);
   localparam logic [YW-1:0]  Y_LAST  = YW'(OutLineCountPx - 1);
   localparam logic signed [WidthIn-1:0] SAT_MAX =
      {{(WidthIn-WidthOut+1){1'b0}}, {(WidthOut-1){1'b1}}};
   localparam logic signed [WidthIn-1:0] SAT_MIN =
      {{(WidthIn-WidthOut+1){1'b1}}, {(WidthOut-1){1'b0}}};

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                         state_r, state_n;
   logic [OutChannels*WidthIn-1:0] cap_r;
   logic [ChW-1:0]                 ch_r, ch_n;
   logic [XW-1:0]                  x_r, x_n;
   logic [YW-1:0]                  y_r, y_n;
   logic                           load;
   logic                           in_fire;
   logic                           out_fire;
   logic                           ch_last;

   logic signed [WidthIn-1:0]      sel;
   logic signed [WidthIn-1:0]      shifted;
   logic signed [WidthIn-1:0]      clamped;

   // State, channel, raster and capture registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= IDLE;
         cap_r   <= '0;
         ch_r    <= '0;
         x_r     <= '0;
         y_r     <= '0;
      end else begin
         state_r <= state_n;
         ch_r    <= ch_n;
         x_r     <= x_n;
         y_r     <= y_n;
         if (load) cap_r <= data_i;
      end
   end

   // Handshakes, next state, channel sequencing and raster advance
   always_comb begin
      state_n  = state_r;
      ch_n     = ch_r;
      x_n      = x_r;
      y_n      = y_r;
      load     = 1'b0;
      ch_last  = (ch_r == CH_LAST);
      valid_o  = (state_r == SEND);
      ready_o  = 1'b0;
      if (!rst_i) begin
         if (state_r == IDLE)
            ready_o = 1'b1;
         else
            ready_o = ch_last & ready_i;
      end
      in_fire  = valid_i & ready_o;
      out_fire = valid_o & ready_i;

      case (state_r)
         IDLE: begin
            if (in_fire) begin
               load    = 1'b1;
               ch_n    = '0;
               state_n = SEND;
            end
         end
         SEND: begin
            if (out_fire) begin
               if (ch_last) begin
                  if (x_r == X_LAST) begin
                     x_n = '0;
                     y_n = (y_r == Y_LAST) ? '0 : y_r + 1'b1;
                  end else begin
                     x_n = x_r + 1'b1;
                  end
                  if (in_fire) begin
                     load = 1'b1;
                     ch_n = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  ch_n = ch_r + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Requantize the currently selected channel from the captured beat
   always_comb begin
      sel = '0;
      for (int c = 0; c < OutChannels; c++) begin
         if (ch_r == ChW'(c)) sel = cap_r[c*WidthIn +: WidthIn];
      end
      shifted = sel >>> ShiftAmt;
`ifdef CONV_OUT_RELU_EN
      clamped = shifted[WidthIn-1] ? '0 : shifted;
`else
      clamped = shifted;
`endif
      if (clamped > SAT_MAX)
         data_o = SAT_MAX[WidthOut-1:0];
      else if (clamped < SAT_MIN)
         data_o = SAT_MIN[WidthOut-1:0];
      else
         data_o = clamped[WidthOut-1:0];
   end

   assign ch_o  = ch_r;
   assign eol_o = valid_o & ch_last & (x_r == X_LAST);
   assign eof_o = eol_o & (y_r == Y_LAST);

endmodule

// File: tb/tb_conv_out_serializer.sv
// Directed bench for conv_out_serializer with a small raster (4x3). A second
// instance with ShiftAmt=2 shares all inputs so the shift path is checked on
// every emitted beat. Expected beats are queued when a pixel is accepted and
// popped by the output monitor.
module tb_conv_out_serializer;

   localparam int W = 4;
   localparam int H = 3;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic [63:0] data_i;
   logic        ready_i;
   logic        ready_o, valid_o, eol_o, eof_o;
   logic [7:0]  data_o;
   logic [0:0]  ch_o;
   logic        ready_o1, valid_o1, eol_o1, eof_o1;
   logic [7:0]  data_o1;
   logic [0:0]  ch_o1;

   conv_out_serializer #(
      .OutLineWidthPx(W), .OutLineCountPx(H), .OutChannels(2),
      .WidthIn(32), .WidthOut(8), .ShiftAmt(0)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
      .ch_o(ch_o), .eol_o(eol_o), .eof_o(eof_o)
   );

   conv_out_serializer #(
      .OutLineWidthPx(W), .OutLineCountPx(H), .OutChannels(2),
      .WidthIn(32), .WidthOut(8), .ShiftAmt(2)
   ) dut_sh2 (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o1),
      .data_i(data_i), .valid_o(valid_o1), .ready_i(ready_i), .data_o(data_o1),
      .ch_o(ch_o1), .eol_o(eol_o1), .eof_o(eof_o1)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [7:0] d0;
      logic [7:0] d1;
      logic       ch;
      logic       eol;
      logic       eof;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   mx = 0;
   int   my = 0;
   int   eol_cnt = 0;
   int   eof_cnt = 0;

   always @(posedge clk_i) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] rq(input int v, input int sh);
      int s;
      s = v >>> sh;
`ifdef CONV_OUT_RELU_EN
      if (s < 0) s = 0;
`endif
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
      return s[7:0];
   endfunction

   task automatic push_pixel(input int d1, input int d0);
      exp_t e;
      for (int c = 0; c < 2; c++) begin
         e.d0  = rq((c == 1) ? d1 : d0, 0);
         e.d1  = rq((c == 1) ? d1 : d0, 2);
         e.ch  = (c == 1);
         e.eol = (c == 1) && (mx == W - 1);
         e.eof = e.eol && (my == H - 1);
         sb.push_back(e);
      end
      if (mx == W - 1) begin
         mx = 0;
         my = (my == H - 1) ? 0 : my + 1;
      end else begin
         mx = mx + 1;
      end
   endtask

   // Presents one pixel and returns the cycle it was accepted and valid_o at that point
   task automatic send_beat(input int d1, input int d0, output int acc, output logic vo);
      valid_i = 1'b1;
      data_i  = {32'(d1), 32'(d0)};
      acc     = -1;
      vo      = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk_i);
         if (ready_o) begin
            acc = cyc;
            vo  = valid_o;
            push_pixel(d1, d0);
            break;
         end
      end
      if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 200; k++) begin
         if (sb.size() == 0) break;
         @(negedge clk_i);
      end
      chk("drain_left", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      sb.delete();
      mx = 0;
      my = 0;
   endtask

   // Scoreboard monitor: every accepted output beat must match the oldest expectation
   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_i && valid_o && ready_i) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_data", 32'(data_o), 32'(e.d0));
            chk("sb_data_sh2", 32'(data_o1), 32'(e.d1));
            chk("sb_ch", 32'(ch_o), 32'(e.ch));
            chk("sb_eol", 32'(eol_o), 32'(e.eol));
            chk("sb_eof", 32'(eof_o), 32'(e.eof));
         end
         if (eol_o) eol_cnt++;
         if (eof_o) eof_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc, prev;
      logic vo;

      // Reset state; a beat presented during reset must be dropped
      rst_i   = 1'b1;
      valid_i = 1'b1;
      data_i  = {32'd55, 32'd66};
      ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_ready", 32'(ready_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_data", 32'(data_o), 32'd0);
      chk("rst_ch", 32'(ch_o), 32'd0);
      chk("rst_eol", 32'(eol_o), 32'd0);
      chk("rst_eof", 32'(eof_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i   = 1'b0;
      valid_i = 1'b0;
      @(negedge clk_i);
      chk("dropped_in_reset", 32'(valid_o), 32'd0);
      chk("idle_ready", 32'(ready_o), 32'd1);
      @(posedge clk_i);
      #1;

      // Single beat, one-cycle latency, then back to idle
      send_beat(-5, 300, acc, vo);
      valid_i = 1'b0;
      @(negedge clk_i);
      chk("t1_valid", 32'(valid_o), 32'd1);
      chk("t1_ch0", 32'(ch_o), 32'd0);
      chk("t1_data0", 32'(data_o), 32'(rq(300, 0)));
      chk("t1_ready_ch0", 32'(ready_o), 32'd0);
      @(negedge clk_i);
      chk("t1_ch1", 32'(ch_o), 32'd1);
      chk("t1_data1", 32'(data_o), 32'(rq(-5, 0)));
      chk("t1_ready_last", 32'(ready_o), 32'd1);
      @(negedge clk_i);
      chk("t1_idle", 32'(valid_o), 32'd0);
      @(posedge clk_i);
      #1;

      // Shift and negative saturation
      send_beat(-13, 13, acc, vo);
      valid_i = 1'b0;
      @(negedge clk_i);
      chk("t2_sh2_ch0", 32'(data_o1), 32'(rq(13, 2)));
      @(negedge clk_i);
      chk("t2_sh2_ch1", 32'(data_o1), 32'(rq(-13, 2)));
      @(posedge clk_i);
      #1;
      send_beat(0, -600, acc, vo);
      valid_i = 1'b0;
      @(negedge clk_i);
      chk("t2_neg_sat", 32'(data_o), 32'(rq(-600, 0)));
      drain();
      @(posedge clk_i);
      #1;

      // Backpressure: outputs hold for 5 cycles, no new beat accepted
      ready_i = 1'b0;
      send_beat(7, -200, acc, vo);
      valid_i = 1'b1;
      data_i  = {32'd1, 32'd1};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         chk("t3_hold_valid", 32'(valid_o), 32'd1);
         chk("t3_hold_data", 32'(data_o), 32'(rq(-200, 0)));
         chk("t3_hold_ch", 32'(ch_o), 32'd0);
         chk("t3_hold_ready", 32'(ready_o), 32'd0);
      end
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      ready_i = 1'b1;
      drain();
      @(posedge clk_i);
      #1;

      // Full-rate streaming: one pixel every 2 cycles, valid_o continuous
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         send_beat(int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000, acc, vo);
         if (i > 0) begin
            chk("t4_interval", 32'(acc - prev), 32'd2);
            chk("t4_valid_at_accept", 32'(vo), 32'd1);
         end
         prev = acc;
      end
      valid_i = 1'b0;
      drain();
      @(posedge clk_i);
      #1;

      // Raster: two 4x3 frames from a fresh reset
      do_reset();
      eol_cnt = 0;
      eof_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         send_beat(i * 40 - 500, 1000 - i * 70, acc, vo);
      end
      valid_i = 1'b0;
      drain();
      chk("t5_eol_count", 32'(eol_cnt), 32'd6);
      chk("t5_eof_count", 32'(eof_cnt), 32'd2);
      @(posedge clk_i);
      #1;

      // Reset while stalled mid-SEND, then raster restarts at the origin
      ready_i = 1'b0;
      send_beat(1, 2, acc, vo);
      valid_i = 1'b0;
      @(negedge clk_i);
      chk("t6_pre_valid", 32'(valid_o), 32'd1);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("t6_valid_after_rst", 32'(valid_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      sb.delete();
      mx = 0;
      my = 0;
      ready_i = 1'b1;
      eol_cnt = 0;
      eof_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         send_beat(-i * 9, i * 33, acc, vo);
      end
      valid_i = 1'b0;
      drain();
      chk("t6_eol_count", 32'(eol_cnt), 32'd1);
      chk("t6_eof_count", 32'(eof_cnt), 32'd0);

      repeat (3) @(posedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
